id_issue: RTL
=============

// Module: id_issue
// PURPOSE
//  RV32I decode/issue stage: decodes the instruction held in the IF/ID register and drives the
//  ID/EX register inputs (a_sel, b_sel, imm, rdn_in, rs2d_in, pc_in). Detects load-use hazards,
//  back-pressures fetch for one cycle and issues a bubble. Honours branch flush. Keeps stall and
//  illegal-instruction counters.
// PARAMETERS
//  WordSize  32  datapath width (PC, imm, register data)
//  CntWidth  16  width of stall_cnt / illegal_cnt (saturating)
// PORTS
//  clk          in   1         clock
//  rstn         in   1         reset, asynchronous, active-low
//  inst_valid   in   1         IF/ID holds a valid instruction
//  inst         in   32        instruction word
//  pc_if        in   WordSize  PC of inst
//  flush        in   1         branch mispredict/redirect: kill the instruction in ID this cycle
//  rs1d_rf      in   WordSize  regfile read data for rs1n
//  rs2d_rf      in   WordSize  regfile read data for rs2n
//  inst_ready   out  1         ID accepts inst this cycle; 0 = hold IF/ID and PC
//  issue_valid  out  1         ID/EX inputs carry a real instruction (0 = bubble)
//  rs1n, rs2n   out  5 each    regfile read addresses (inst[19:15], inst[24:20])
//  a_sel        out  2         0=rs1 1=pc 3=zero
//  b_sel        out  2         0=rs2 1=imm 2=const 4 3=imm<<12
//  imm          out  WordSize  sign-extended immediate; U-type gives inst[31:12] unshifted
//  rdn          out  5         destination register; 0 when no writeback
//  pc           out  WordSize  pass-through of pc_if
//  rs1d, rs2d   out  WordSize  pass-through of rs1d_rf / rs2d_rf
//  is_load      out  1         issued instruction is a LOAD
//  illegal      out  1         1-cycle pulse: unsupported opcode seen (valid, not flushed)
//  stall_cnt    out  CntWidth  load-use stall cycles since reset, saturating
//  illegal_cnt  out  CntWidth  illegal instructions since reset, saturating
// BEHAVIOUR
//  - Decode is combinational from inst. Registered state: fsm, prev_load, prev_rdn, both counters.
//  - Bubble outputs: issue_valid=0, rdn=0, a_sel=3, b_sel=2, imm=0, is_load=0.
//  - Reset: fsm=ISSUE, prev_load=0, prev_rdn=0, counters=0.
//    Outputs during reset: bubble values, inst_ready=1, illegal=0.
//  - Operand selection by opcode:
//    . OP: a0 b0.
//    . OP-IMM, LOAD, STORE, JALR: a0 b1.
//    . BRANCH: a0 b0.
//    . LUI: a3 b3.
//    . AUIPC: a1 b3.
//    . JAL: a1 b2.
//    . JALR writes link via EX.
//    . rdn = inst[11:7] for OP/OP-IMM/LOAD/LUI/AUIPC/JAL/JALR; 0 for STORE/BRANCH.
//  - Immediates: I/S/B/J sign-extended to WordSize per RV32I (B/J with bit0=0). U = {0, inst[31:12]}.
//  - Hazard: prev_load && prev_rdn!=0 && current instruction uses prev_rdn.
//    . rs1 is used by all opcodes except LUI/AUIPC/JAL.
//    . rs2 is used only by OP/STORE/BRANCH.
//  - FSM ISSUE:
//    . flush -> bubble, inst_ready=1, prev_load<=0, prev_rdn<=0. Flush beats hazard and illegal.
//    . !inst_valid -> bubble, inst_ready=1, prev_load<=0, prev_rdn<=0.
//    . hazard -> bubble, inst_ready=0, stall_cnt++, go STALL, prev_load<=0.
//    . illegal -> bubble, inst_ready=1, illegal=1, illegal_cnt++, prev_load<=0.
//    . else -> issue; prev_load<=is_load, prev_rdn<=rdn.
//  - FSM STALL (exactly 1 cycle): same inst re-presented. Issue unconditionally (hazard cleared
//    because prev_load=0), update prev_*, return to ISSUE. Flush in STALL -> bubble, return to ISSUE.
//  - Counters saturate at all-ones; never wrap.
//  - inst_ready is combinational. IF must not change inst while inst_ready=0.
//  - Async reset mid-stall returns to ISSUE with bubble outputs immediately.
// TESTING
//  - Reset: rstn=0 -> issue_valid=0, rdn=0, a_sel=3, b_sel=2, inst_ready=1, counters 0.
//  - addi x5,x0,-1 (0xFFF00293), pc=0x100 -> a_sel=0, b_sel=1, imm=0xFFFFFFFF, rdn=5, pc=0x100.
//  - lui x1,0x12345 -> a_sel=3, b_sel=3, imm=0x00012345, rdn=1.
//    auipc -> a_sel=1, b_sel=3.
//    jal x1 -> a_sel=1, b_sel=2.
//  - lw x3,0(x2) then add x4,x3,x1:
//    . cycle 2: bubble, inst_ready=0, stall_cnt=1.
//    . cycle 3: add issues, rdn=4.
//    Repeat with sw x3,0(x9): stalls.
//    Repeat with lw x0: no stall.
//  - lw x3 then add x4,x3,x1 with flush=1 in cycle 2: bubble, inst_ready=1, stall_cnt unchanged.
//    FSM=ISSUE.
//  - opcode 0x7F -> illegal pulse 1 cycle, bubble, illegal_cnt=1.
//    CntWidth=2, 5 illegals -> illegal_cnt=3.

Source files
------------

// File: rtl/id_issue.sv
// RV32I decode/issue stage: combinational decode of the IF/ID instruction into ID/EX inputs,
// one-cycle load-use stall, branch flush handling, saturating stall/illegal counters.
module id_issue #(
  parameter int WordSize = 32,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                inst_valid,
  input  logic [31:0]         inst,
  input  logic [WordSize-1:0] pc_if,
  input  logic                flush,
  input  logic [WordSize-1:0] rs1d_rf,
  input  logic [WordSize-1:0] rs2d_rf,
  output logic                inst_ready,
  output logic                issue_valid,
  output logic [4:0]          rs1n,
  output logic [4:0]          rs2n,
  output logic [1:0]          a_sel,
  output logic [1:0]          b_sel,
  output logic [WordSize-1:0] imm,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] rs1d,
  output logic [WordSize-1:0] rs2d,
  output logic                is_load,
  output logic                illegal,
  output logic [CntWidth-1:0] stall_cnt,
  output logic [CntWidth-1:0] illegal_cnt,
  output logic                o_dbg_state
);

  // Handshake: inst is consumed on a rising clk edge where inst_valid && inst_ready; while
  // inst_ready=0 IF holds inst/pc_if stable. issue_valid has no ready: EX always takes it.

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [1:0] ASelRs1  = 2'd0;
  localparam logic [1:0] ASelPc   = 2'd1;
  localparam logic [1:0] ASelZero = 2'd3;
  localparam logic [1:0] BSelRs2  = 2'd0;
  localparam logic [1:0] BSelImm  = 2'd1;
  localparam logic [1:0] BSelFour = 2'd2;
  localparam logic [1:0] BSelUImm = 2'd3;

  localparam logic [CntWidth-1:0] CntOne = 1;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prev_load;
  logic [4:0]          r_prev_rdn;
  logic [CntWidth-1:0] r_stall_cnt;
  logic [CntWidth-1:0] r_illegal_cnt;

  logic                w_prev_load_nxt;
  logic [4:0]          w_prev_rdn_nxt;
  logic                w_stall_inc;
  logic                w_illegal_inc;
  logic                w_issue;

  logic [WordSize-1:0] w_imm_i;
  logic [WordSize-1:0] w_imm_s;
  logic [WordSize-1:0] w_imm_b;
  logic [WordSize-1:0] w_imm_j;
  logic [WordSize-1:0] w_imm_u;

  logic                w_legal;
  logic [1:0]          w_dec_a;
  logic [1:0]          w_dec_b;
  logic [WordSize-1:0] w_dec_imm;
  logic [4:0]          w_dec_rdn;
  logic                w_dec_load;
  logic                w_use_rs1;
  logic                w_use_rs2;
  logic                w_hazard;

  assign w_imm_i = {{(WordSize-12){inst[31]}}, inst[31:20]};
  assign w_imm_s = {{(WordSize-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b = {{(WordSize-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_j = {{(WordSize-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  // U-type immediate is delivered unshifted; EX applies the <<12 via b_sel=3.
  assign w_imm_u = {{(WordSize-20){1'b0}}, inst[31:12]};

  assign rs1n = inst[19:15];
  assign rs2n = inst[24:20];
  assign pc   = pc_if;
  assign rs1d = rs1d_rf;
  assign rs2d = rs2d_rf;

  assign stall_cnt   = r_stall_cnt;
  assign illegal_cnt = r_illegal_cnt;
  assign o_dbg_state = (r_state == ST_STALL);

  always_comb begin
    w_legal    = 1'b1;
    w_dec_a    = ASelRs1;
    w_dec_b    = BSelRs2;
    w_dec_imm  = '0;
    w_dec_rdn  = inst[11:7];
    w_dec_load = 1'b0;
    w_use_rs1  = 1'b1;
    w_use_rs2  = 1'b0;
    case (inst[6:0])
      OpOp: begin
        w_use_rs2 = 1'b1;
      end
      OpOpImm, OpJalr: begin
        w_dec_b   = BSelImm;
        w_dec_imm = w_imm_i;
      end
      OpLoad: begin
        w_dec_b    = BSelImm;
        w_dec_imm  = w_imm_i;
        w_dec_load = 1'b1;
      end
      OpStore: begin
        w_dec_b   = BSelImm;
        w_dec_imm = w_imm_s;
        w_dec_rdn = 5'd0;
        w_use_rs2 = 1'b1;
      end
      OpBranch: begin
        w_dec_imm = w_imm_b;
        w_dec_rdn = 5'd0;
        w_use_rs2 = 1'b1;
      end
      OpJal: begin
        w_dec_a   = ASelPc;
        w_dec_b   = BSelFour;
        w_dec_imm = w_imm_j;
        w_use_rs1 = 1'b0;
      end
      OpLui: begin
        w_dec_a   = ASelZero;
        w_dec_b   = BSelUImm;
        w_dec_imm = w_imm_u;
        w_use_rs1 = 1'b0;
      end
      OpAuipc: begin
        w_dec_a   = ASelPc;
        w_dec_b   = BSelUImm;
        w_dec_imm = w_imm_u;
        w_use_rs1 = 1'b0;
      end
      default: begin
        w_legal   = 1'b0;
        w_dec_rdn = 5'd0;
        w_use_rs1 = 1'b0;
      end
    endcase
  end

  // Only legal instructions can stall; an unsupported opcode is reported, never held.
  assign w_hazard = w_legal && r_prev_load && (r_prev_rdn != 5'd0) &&
                    ((w_use_rs1 && (rs1n == r_prev_rdn)) ||
                     (w_use_rs2 && (rs2n == r_prev_rdn)));

  always_comb begin
    w_state_nxt     = r_state;
    w_prev_load_nxt = r_prev_load;
    w_prev_rdn_nxt  = r_prev_rdn;
    w_stall_inc     = 1'b0;
    w_illegal_inc   = 1'b0;
    w_issue         = 1'b0;
    inst_ready      = 1'b1;
    illegal         = 1'b0;
    issue_valid     = 1'b0;
    rdn             = 5'd0;
    a_sel           = ASelZero;
    b_sel           = BSelFour;
    imm             = '0;
    is_load         = 1'b0;

    if (rstn) begin
      case (r_state)
        ST_ISSUE: begin
          if (flush || !inst_valid) begin
            w_prev_load_nxt = 1'b0;
            w_prev_rdn_nxt  = 5'd0;
          end else if (w_hazard) begin
            inst_ready      = 1'b0;
            w_stall_inc     = 1'b1;
            w_prev_load_nxt = 1'b0;
            w_state_nxt     = ST_STALL;
          end else if (!w_legal) begin
            illegal         = 1'b1;
            w_illegal_inc   = 1'b1;
            w_prev_load_nxt = 1'b0;
          end else begin
            w_issue = 1'b1;
          end
        end
        ST_STALL: begin
          // prev_load was cleared on entry, so the held instruction no longer conflicts.
          w_state_nxt = ST_ISSUE;
          if (flush) begin
            w_prev_load_nxt = 1'b0;
            w_prev_rdn_nxt  = 5'd0;
          end else begin
            w_issue = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ISSUE;
        end
      endcase
    end

    if (w_issue) begin
      issue_valid     = 1'b1;
      rdn             = w_dec_rdn;
      a_sel           = w_dec_a;
      b_sel           = w_dec_b;
      imm             = w_dec_imm;
      is_load         = w_dec_load;
      w_prev_load_nxt = w_dec_load;
      w_prev_rdn_nxt  = w_dec_rdn;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_ISSUE;
      r_prev_load   <= 1'b0;
      r_prev_rdn    <= 5'd0;
      r_stall_cnt   <= '0;
      r_illegal_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_load <= w_prev_load_nxt;
      r_prev_rdn  <= w_prev_rdn_nxt;
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (w_illegal_inc && (r_illegal_cnt != '1)) begin
        r_illegal_cnt <= r_illegal_cnt + CntOne;
      end
    end
  end

endmodule
